// File: rtl/mole_anim_pkg.sv
// Shared types and default constants for the per-hole mole animation engine.
package mole_anim_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RISE = 3'd1,
        HOLD = 3'd2,
        FALL = 3'd3,
        HITR = 3'd4,
        COOL = 3'd5
    } mole_state_t;

    localparam logic [3:0] NO_HOLE      = 4'hf;
    localparam int         DEF_N_FRAMES = 16;
    localparam int         DEF_TICK_DIV = 3125000;
    localparam int         DEF_HIT_STEP = 2;

endpackage

// File: rtl/mole_anim_channel.sv
// One hole: state machine plus frame register, advanced on the shared animation tick.
module mole_anim_channel
    import mole_anim_pkg::*;
#(
    parameter int FRAME_W  = 5,
    parameter int N_FRAMES = DEF_N_FRAMES,
    parameter int HIT_STEP = DEF_HIT_STEP
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_tick,
    input  logic               i_map,
    input  logic               i_hit,
    output logic [FRAME_W-1:0] o_frame,
    output logic               o_up,
    output logic               o_busy
);

    localparam logic [FRAME_W-1:0] TOP  = FRAME_W'(N_FRAMES);
    localparam logic [FRAME_W-1:0] STEP = FRAME_W'(HIT_STEP);
    localparam logic [FRAME_W-1:0] ONE  = FRAME_W'(1);

    mole_state_t        r_state, w_state_next;
    logic [FRAME_W-1:0] r_frame, w_frame_next;
    logic [FRAME_W-1:0] w_up1, w_dn1, w_dnh;

    assign w_up1 = r_frame + ONE;
    assign w_dn1 = r_frame - ONE;
    assign w_dnh = (r_frame > STEP) ? (r_frame - STEP) : '0;

    always_comb begin
        w_state_next = r_state;
        w_frame_next = r_frame;
        // A whack preempts any tick-driven move on the same cycle.
        if (i_hit && (r_state == RISE || r_state == HOLD)) begin
            w_state_next = HITR;
        end else if (i_tick) begin
            case (r_state)
                IDLE: begin
                    if (i_map) begin
                        w_state_next = RISE;
                        w_frame_next = ONE;
                    end
                end
                RISE, FALL: begin
                    // Direction follows map; landing on an end stop settles the state.
                    if (i_map) begin
                        w_frame_next = w_up1;
                        w_state_next = (w_up1 == TOP) ? HOLD : RISE;
                    end else begin
                        w_frame_next = w_dn1;
                        w_state_next = (w_dn1 == '0) ? IDLE : FALL;
                    end
                end
                HOLD: begin
                    if (!i_map) begin
                        w_state_next = FALL;
                        w_frame_next = TOP - ONE;
                    end
                end
                HITR: begin
                    w_frame_next = w_dnh;
                    if (w_dnh == '0) w_state_next = i_map ? COOL : IDLE;
                end
                COOL: begin
                    if (!i_map) w_state_next = IDLE;
                end
                default: begin
                    w_state_next = IDLE;
                    w_frame_next = '0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state <= IDLE;
            r_frame <= '0;
        end else begin
            r_state <= w_state_next;
            r_frame <= w_frame_next;
        end
    end

    assign o_frame = r_frame;
    assign o_up    = (r_state == HOLD);
    assign o_busy  = (r_state != IDLE);

endmodule

// File: rtl/mole_anim_engine.sv
// Per-hole mole animation: shared tick prescaler, N_HOLES channels, packed outputs and
// the pixel-path frame lookup.
module mole_anim_engine
    import mole_anim_pkg::*;
#(
    parameter int N_HOLES  = 9,
    parameter int FRAME_W  = 5,
    parameter int N_FRAMES = DEF_N_FRAMES,
    parameter int TICK_DIV = DEF_TICK_DIV,
    parameter int HIT_STEP = DEF_HIT_STEP
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [N_HOLES-1:0]         i_map,
    input  logic [N_HOLES-1:0]         i_hit,
    input  logic [3:0]                 i_sel_hole,
    output logic [FRAME_W-1:0]         o_sel_frame,
    output logic [N_HOLES*FRAME_W-1:0] o_frames,
    output logic [N_HOLES-1:0]         o_state_up,
    output logic                       o_anim_busy
);

    localparam int                CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0]   r_cnt;
    logic               w_tick;
    logic [FRAME_W-1:0] w_frame [N_HOLES];
    logic [N_HOLES-1:0] w_busy;
    logic [FRAME_W-1:0] w_sel_frame;

    assign w_tick = (r_cnt == CNT_LAST);

    always_ff @(posedge i_clk) begin
        if (!i_rst) r_cnt <= '0;
        else        r_cnt <= w_tick ? '0 : r_cnt + CNT_W'(1);
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_HOLES; gi++) begin : g_ch
            mole_anim_channel #(
                .FRAME_W  (FRAME_W),
                .N_FRAMES (N_FRAMES),
                .HIT_STEP (HIT_STEP)
            ) u_ch (
                .i_clk   (i_clk),
                .i_rst   (i_rst),
                .i_tick  (w_tick),
                .i_map   (i_map[gi]),
                .i_hit   (i_hit[gi]),
                .o_frame (w_frame[gi]),
                .o_up    (o_state_up[gi]),
                .o_busy  (w_busy[gi])
            );
            assign o_frames[gi*FRAME_W +: FRAME_W] = w_frame[gi];
        end
    endgenerate

    // Indices at or above N_HOLES (including the reserved "none" code) read as frame 0.
    always_comb begin
        w_sel_frame = '0;
        for (int i = 0; i < N_HOLES; i++) begin
            if (i_sel_hole != NO_HOLE && i_sel_hole == 4'(i)) w_sel_frame = w_frame[i];
        end
    end

    assign o_sel_frame = w_sel_frame;
    assign o_anim_busy = |w_busy;

endmodule

// File: tb/tb_mole_anim_engine.sv
// Directed and randomized bench for mole_anim_engine against a frame/mode-level model.
module tb_mole_anim_engine;

    localparam int NH = 9;
    localparam int FW = 5;
    localparam int NF = 4;
    localparam int TD = 4;
    localparam int HS = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NH-1:0]     map = '0;
    logic [NH-1:0]     hit = '0;
    logic [3:0]        sel = 4'hf;
    logic [FW-1:0]     sel_frame;
    logic [NH*FW-1:0]  frames;
    logic [NH-1:0]     state_up;
    logic              anim_busy;

    int total = 0;
    int bad   = 0;
    bit verbose = 1'b1;

    // Model: each mole is a height plus a mode (normal / retracting / cooling).
    int m_frame   [NH];
    bit m_last_up [NH];
    bit m_retr    [NH];
    bit m_cool    [NH];
    int m_cnt;

    mole_anim_engine #(
        .N_HOLES  (NH),
        .FRAME_W  (FW),
        .N_FRAMES (NF),
        .TICK_DIV (TD),
        .HIT_STEP (HS)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst_n),
        .i_map       (map),
        .i_hit       (hit),
        .i_sel_hole  (sel),
        .o_sel_frame (sel_frame),
        .o_frames    (frames),
        .o_state_up  (state_up),
        .o_anim_busy (anim_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input bit r, input logic [NH-1:0] m, input logic [NH-1:0] h);
        bit tick;
        if (!r) begin
            m_cnt = 0;
            for (int i = 0; i < NH; i++) begin
                m_frame[i] = 0; m_last_up[i] = 0; m_retr[i] = 0; m_cool[i] = 0;
            end
            return;
        end
        tick  = (m_cnt == TD - 1);
        m_cnt = tick ? 0 : m_cnt + 1;
        for (int i = 0; i < NH; i++) begin
            if (h[i] && !m_retr[i] && !m_cool[i] && m_frame[i] > 0 && m_last_up[i]) begin
                m_retr[i] = 1;
            end else if (tick) begin
                if (m_retr[i]) begin
                    m_frame[i] = (m_frame[i] > HS) ? m_frame[i] - HS : 0;
                    if (m_frame[i] == 0) begin
                        m_retr[i] = 0;
                        m_cool[i] = m[i];
                    end
                end else if (m_cool[i]) begin
                    if (!m[i]) m_cool[i] = 0;
                end else begin
                    if (m[i]) m_frame[i] = (m_frame[i] < NF) ? m_frame[i] + 1 : NF;
                    else      m_frame[i] = (m_frame[i] > 0) ? m_frame[i] - 1 : 0;
                    m_last_up[i] = m[i];
                end
            end
        end
    endtask

    task automatic check_all();
        logic [NH-1:0] exp_up;
        logic          exp_busy;
        int            exp_sel;
        exp_up   = '0;
        exp_busy = 1'b0;
        for (int i = 0; i < NH; i++) begin
            chk($sformatf("frame%0d", i), 32'(frames[i*FW +: FW]), 32'(m_frame[i]));
            exp_up[i] = !m_retr[i] && !m_cool[i] && (m_frame[i] == NF);
            if (m_retr[i] || m_cool[i] || m_frame[i] != 0) exp_busy = 1'b1;
        end
        exp_sel = (int'(sel) < NH) ? m_frame[sel] : 0;
        chk("state_up", 32'(state_up), 32'(exp_up));
        chk("anim_busy", 32'(anim_busy), 32'(exp_busy));
        chk("sel_frame", 32'(sel_frame), 32'(exp_sel));
    endtask

    task automatic step(input bit r, input logic [NH-1:0] m, input logic [NH-1:0] h,
                        input logic [3:0] s);
        @(negedge clk);
        rst_n = r; map = m; hit = h; sel = s;
        @(posedge clk);
        model_edge(r, m, h);
        #1;
        check_all();
        if (verbose)
            $display("step rst=%0b map=%03h hit=%03h sel=%0d frames=%h up=%03h busy=%0b",
                     r, m, h, s, frames, state_up, anim_busy);
    endtask

    task automatic repeat_step(input int n, input logic [NH-1:0] m, input logic [3:0] s);
        for (int k = 0; k < n; k++) step(1'b1, m, '0, s);
    endtask

    initial begin
        logic [NH-1:0] rmap;
        logic [NH-1:0] rhit;
        bit            rrst;

        // Reset held with every hole requested.
        for (int k = 0; k < 3; k++) step(1'b0, '1, '0, 4'd0);
        chk("rst_busy", 32'(anim_busy), 32'(0));
        chk("rst_frames", 32'(frames == '0), 32'(1));

        // Hole 0 rises to the top and holds, then falls back.
        repeat_step(20, 9'h001, 4'd0);
        chk("hold0_frame", 32'(frames[0 +: FW]), 32'(NF));
        chk("hold0_up", 32'(state_up[0]), 32'(1));
        repeat_step(20, 9'h000, 4'd0);
        chk("fall0_busy", 32'(anim_busy), 32'(0));

        // Hole 3: whack at the top, retract to cool-down, release, rise again.
        repeat_step(20, 9'h008, 4'd3);
        step(1'b1, 9'h008, 9'h008, 4'd3);
        repeat_step(20, 9'h008, 4'd3);
        chk("cool3_frame", 32'(frames[3*FW +: FW]), 32'(0));
        chk("cool3_busy", 32'(anim_busy), 32'(1));
        repeat_step(8, 9'h000, 4'd3);
        chk("idle3_busy", 32'(anim_busy), 32'(0));
        repeat_step(8, 9'h008, 4'd3);
        chk("rerise3", 32'(frames[3*FW +: FW]), 32'(2));
        repeat_step(8, 9'h000, 4'd3);

        // Hole 5: reversal mid-rise, then hit on the same cycle map drops.
        repeat_step(8, 9'h020, 4'd5);
        repeat_step(4, 9'h000, 4'd5);
        chk("rev5_down", 32'(frames[5*FW +: FW]), 32'(1));
        repeat_step(12, 9'h020, 4'd5);
        chk("rev5_top", 32'(frames[5*FW +: FW]), 32'(NF));
        chk("sel5", 32'(sel_frame), 32'(NF));
        step(1'b1, 9'h020, '0, 4'd12);
        chk("sel12", 32'(sel_frame), 32'(0));
        step(1'b1, 9'h020, '0, 4'hf);
        chk("selnone", 32'(sel_frame), 32'(0));
        step(1'b1, 9'h000, 9'h020, 4'd5);
        repeat_step(12, 9'h000, 4'd5);
        chk("hit5_idle", 32'(frames[5*FW +: FW]), 32'(0));

        // Reset mid-rise aborts on that edge.
        repeat_step(8, 9'h001, 4'd0);
        chk("pre_rst0", 32'(frames[0 +: FW]), 32'(2));
        step(1'b0, 9'h001, '0, 4'd0);
        chk("midrst0", 32'(frames[0 +: FW]), 32'(0));
        chk("midrst_busy", 32'(anim_busy), 32'(0));

        // Randomized traffic against the model.
        verbose = 1'b0;
        rmap = '0;
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < NH; i++) begin
                if ($urandom_range(11) == 0) rmap[i] = ~rmap[i];
                rhit[i] = ($urandom_range(9) == 0);
            end
            rrst = ($urandom_range(299) != 0);
            step(rrst, rmap, rhit, 4'($urandom_range(15)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
